// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
// Shared definitions for the sequential shift-add multiplier.
//   - state_t   : FSM encoding (IDLE=0, BUSY=1, DONE=2)
//   - clog2()   : bit width needed to count 0..value-1
//   - cnt_width(): step-counter width, never less than one bit
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

  function automatic int cnt_width(input int width);
    return (clog2(width) < 1) ? 1 : clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl
// Handshake FSM and step counter for the sequential multiplier.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, out_ready : upstream / downstream handshake inputs
//   in_ready            : high only in IDLE
//   out_valid           : high only in DONE
//   busy                : high in BUSY or DONE
//   load                : operand accept strobe (IDLE and in_valid)
//   step                : one shift-add step this cycle (BUSY)
//   done_load           : final step, product register loads this cycle
//   cnt                 : index of the multiplier bit handled this cycle
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          in_ready,
  output logic          out_valid,
  output logic          busy,
  output logic          load,
  output logic          step,
  output logic          done_load,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_next;

  // State register and step counter; the counter restarts on every accept
  // so a new operation never inherits a stale step index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (load || done_load) begin
        cnt <= '0;
      end else if (step) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Next-state and strobe decode. The last step is recognised by the
  // counter value at the edge, so DONE is entered exactly WIDTH edges
  // after the accept edge regardless of operand values.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    done_load  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        step = 1'b1;
        if (cnt == LAST) begin
          done_load  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier
// Sequential shift-add multiplier, one multiplier bit per clock, with
// valid/ready handshakes on operands and product.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : a/b valid;  in_ready : accepting (IDLE only)
//   a, b         : WIDTH-bit multiplicand / multiplier
//   signed_mode  : (SEQ_MULT_SIGNED_EN only) treat a/b as two's complement
//   out_valid    : p valid (DONE only);  out_ready : consumer takes p
//   p            : 2*WIDTH-bit product, held after the handshake
//   busy         : high in BUSY or DONE
// Build option: define SEQ_MULT_SIGNED_EN to add signed_mode. Signed
// operands are converted to magnitudes at accept, the unsigned core runs
// unchanged, and the product is negated when it is loaded if signs differ.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               signed_mode,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic               neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_in;
  logic               load;
  logic               step;
  logic               done_load;
  logic [CW-1:0]      cnt;

  seq_mult_ctrl #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .busy      (busy),
    .load      (load),
    .step      (step),
    .done_load (done_load),
    .cnt       (cnt)
  );

`ifdef SEQ_MULT_SIGNED_EN
  // The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits in
  // WIDTH unsigned bits, so the most negative operand stays exact.
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    neg_in = 1'b0;
    if (signed_mode) begin
      if (a[WIDTH-1]) a_mag = -a;
      if (b[WIDTH-1]) b_mag = -b;
      neg_in = a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign neg_in = 1'b0;
`endif

  // Partial product for this step; the final step's contribution is folded
  // in here so p can be loaded on the same edge that leaves BUSY.
  always_comb begin
    acc_next = acc;
    if (mplier[0]) begin
      acc_next = acc + ({{WIDTH{1'b0}}, mcand} << cnt);
    end
  end

  // Datapath registers. p only changes on the final step, so it holds
  // through DONE and keeps its value after the product handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      p      <= '0;
    end else if (load) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      acc    <= '0;
      neg    <= neg_in;
    end else if (step) begin
      acc    <= acc_next;
      mplier <= mplier >> 1;
      if (done_load) begin
        p <= neg ? -acc_next : acc_next;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier
// Self-checking bench for seq_multiplier: a WIDTH=4 instance driven from a
// vector table plus hand-written backpressure and mid-operation reset
// sequences, and a WIDTH=8 instance for the wide corner cases.
// With SEQ_MULT_SIGNED_EN defined, signed vectors are also applied.
module tb_seq_multiplier;

  logic       clk;
  logic       rst_n;

  logic       in_valid4;
  logic       in_ready4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       signed_mode4;
  logic       out_valid4;
  logic       out_ready4;
  logic [7:0] p4;
  logic       busy4;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        signed_mode8;
  logic        out_valid8;
  logic        out_ready8;
  logic [15:0] p8;
  logic        busy8;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sm;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];
`ifdef SEQ_MULT_SIGNED_EN
  vec_t svecs[4];
`endif

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid4),
    .in_ready    (in_ready4),
    .a           (a4),
    .b           (b4),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode (signed_mode4),
`endif
    .out_valid   (out_valid4),
    .out_ready   (out_ready4),
    .p           (p4),
    .busy        (busy4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid8),
    .in_ready    (in_ready8),
    .a           (a8),
    .b           (b8),
`ifdef SEQ_MULT_SIGNED_EN
    .signed_mode (signed_mode8),
`endif
    .out_valid   (out_valid8),
    .out_ready   (out_ready8),
    .p           (p8),
    .busy        (busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One WIDTH=4 transaction: accept, measure latency, poke ignored operands
  // while busy, optionally hold out_ready low for 'hold' cycles, handshake.
  task automatic apply_stimulus(input logic [3:0] va, input logic [3:0] vb,
                                input logic vsm, input logic [7:0] vexp,
                                input int hold, input string name);
    int lat;
    @(negedge clk);
    out_ready4   = (hold == 0);
    a4           = va;
    b4           = vb;
    signed_mode4 = vsm;
    in_valid4    = 1'b1;
    check_output({name, " in_ready before accept"}, 32'(in_ready4), 32'd1);
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid4 && lat < 40) begin
      if (lat == 1) begin
        in_valid4 = 1'b1;
        a4        = ~va;
        b4        = ~vb;
      end else begin
        in_valid4 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (lat == 2) begin
        check_output({name, " in_ready while busy"}, 32'(in_ready4), 32'd0);
        check_output({name, " busy while busy"}, 32'(busy4), 32'd1);
      end
    end
    in_valid4 = 1'b0;
    check_output({name, " latency"}, 32'(lat), 32'd4);
    check_output({name, " product"}, 32'(p4), 32'(vexp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_output({name, " held out_valid"}, 32'(out_valid4), 32'd1);
      check_output({name, " held product"}, 32'(p4), 32'(vexp));
    end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    check_output({name, " in_ready after handshake"}, 32'(in_ready4), 32'd1);
    check_output({name, " out_valid after handshake"}, 32'(out_valid4), 32'd0);
    check_output({name, " product kept"}, 32'(p4), 32'(vexp));
  endtask

  task automatic apply_wide(input logic [7:0] va, input logic [7:0] vb,
                            input logic [15:0] vexp, input string name);
    int lat;
    @(negedge clk);
    a8        = va;
    b8        = vb;
    in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output({name, " latency"}, 32'(lat), 32'd8);
    check_output({name, " product"}, 32'(p8), 32'(vexp));
    @(posedge clk); #1;
    check_output({name, " in_ready after handshake"}, 32'(in_ready8), 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{a: 4'd3,  b: 4'd2,  sm: 1'b0, exp: 8'd6};
    vecs[1] = '{a: 4'd5,  b: 4'd3,  sm: 1'b0, exp: 8'd15};
    vecs[2] = '{a: 4'd15, b: 4'd1,  sm: 1'b0, exp: 8'd15};
    vecs[3] = '{a: 4'd9,  b: 4'd9,  sm: 1'b0, exp: 8'd81};
    vecs[4] = '{a: 4'd15, b: 4'd15, sm: 1'b0, exp: 8'd225};
    vecs[5] = '{a: 4'd0,  b: 4'd9,  sm: 1'b0, exp: 8'd0};
    vecs[6] = '{a: 4'd1,  b: 4'd14, sm: 1'b0, exp: 8'd14};
`ifdef SEQ_MULT_SIGNED_EN
    svecs[0] = '{a: 4'hD, b: 4'd5, sm: 1'b1, exp: 8'hF1};
    svecs[1] = '{a: 4'h8, b: 4'h8, sm: 1'b1, exp: 8'd64};
    svecs[2] = '{a: 4'hD, b: 4'd5, sm: 1'b0, exp: 8'd65};
    svecs[3] = '{a: 4'd7, b: 4'hF, sm: 1'b1, exp: 8'hF9};
`endif

    rst_n        = 1'b0;
    in_valid4    = 1'b0;
    a4           = '0;
    b4           = '0;
    signed_mode4 = 1'b0;
    out_ready4   = 1'b1;
    in_valid8    = 1'b0;
    a8           = '0;
    b8           = '0;
    signed_mode8 = 1'b0;
    out_ready8   = 1'b1;

    #12;
    check_output("reset in_ready", 32'(in_ready4), 32'd1);
    check_output("reset out_valid", 32'(out_valid4), 32'd0);
    check_output("reset busy", 32'(busy4), 32'd0);
    check_output("reset p", 32'(p4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp, 0,
                     $sformatf("vec%0d", i));
    end

    apply_stimulus(4'd7, 4'd6, 1'b0, 8'd42, 10, "backpressure 7*6");

    apply_wide(8'd255, 8'd255, 16'd65025, "w8 255*255");
    apply_wide(8'd0, 8'd200, 16'd0, "w8 0*200");

    // Reset two cycles into a 9*9 must discard everything immediately.
    @(negedge clk);
    a4        = 4'd9;
    b4        = 4'd9;
    in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_output("mid reset out_valid", 32'(out_valid4), 32'd0);
    check_output("mid reset p", 32'(p4), 32'd0);
    check_output("mid reset in_ready", 32'(in_ready4), 32'd1);
    check_output("mid reset busy", 32'(busy4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(4'd2, 4'd2, 1'b0, 8'd4, 0, "after reset 2*2");

`ifdef SEQ_MULT_SIGNED_EN
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(svecs[i].a, svecs[i].b, svecs[i].sm, svecs[i].exp, 0,
                     $sformatf("svec%0d", i));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised sequential shift-add unsigned multiplier with a valid/ready handshake on both the operand side and the product side. It computes one product bit-step per clock, trading latency for area. It replaces the fixed 4-bit combinational multiplier in arithmetic datapaths where WIDTH varies or timing is tight. The optional signed mode adds two's-complement operation.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32; product width is 2*WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair a/b is valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
out_valid  output  1  product p is valid (high only in DONE)
out_ready  input  1  consumer accepts p
p  output  2*WIDTH  product
busy  output  1  high in BUSY or DONE

Behaviour:
- Reset (async assert, synchronous deassert by the system): state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, and all internal registers cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - register a into mcand and b into mplier;
  - clear acc (2*WIDTH bits) and set cnt=0;
  - go to BUSY.
- BUSY: each edge performs one step:
  - if mplier[0]=1, acc += mcand << cnt;
  - mplier >>= 1; cnt++;
  - when cnt==WIDTH-1 at the edge, load p with the final acc and go to DONE.
- in_valid and operand changes during BUSY or DONE are ignored; no queuing.
- Latency: the accept edge is k. out_valid rises after edge k+WIDTH and is visible for the whole following cycle.
- DONE: out_valid=1, and p stays stable until out_ready=1. On an edge with out_ready=1, go to IDLE with out_valid=0. p keeps its last value; it is not cleared.
- Throughput: one product per WIDTH+2 cycles at best. in_ready reasserts the cycle after the product handshake, with no same-cycle overlap.
- Arithmetic: unsigned, with no overflow possible in 2*WIDTH bits. Maximum result is (2^WIDTH-1)^2; for WIDTH=4, 15*15=225.
- Zero operands still take the full WIDTH cycles; there is no early termination.
- Reset mid-operation: any state returns immediately to the reset values and the partial result is discarded.
- out_ready held high before DONE has no effect until DONE.

Optional Feature:
Macro SEQ_MULT_SIGNED_EN.
- Defined:
  - adds input port signed_mode (1 bit), sampled only at the accept edge;
  - when signed_mode=1, a and b are two's complement: magnitudes are registered, the unsigned core runs unchanged, and p is negated in the DONE-load step if the operand signs differ;
  - -2^(WIDTH-1) * -2^(WIDTH-1) gives +2^(2*WIDTH-2) and must be exact;
  - latency is unchanged.
- Undefined: no signed_mode port; behaviour is purely unsigned.

Decomposition:
- Package seq_mult_pkg holds:
  - the state encodings as localparams: IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - the count-width function clog2(WIDTH).
- One natural sub-module, seq_mult_ctrl: FSM plus cnt, producing in_ready, out_valid, busy, load, step and done_load strobes.
- Datapath registers (mcand, mplier, acc, p) stay in the top module.

Test Plan:
- WIDTH=4: a=3, b=2 accepted at edge k -> out_valid after edge k+4, p=6 (8'b00000110).
- WIDTH=4, sequence 5*3, 15*1, 9*9 with out_ready tied high -> p=15, 15, 81, each with 4-cycle latency; in_ready is low during BUSY/DONE, and in_valid pulses in that window are ignored.
- WIDTH=8: a=255, b=255 -> p=65025. Then a=0, b=200 -> p=0 after the full 8 cycles.
- Backpressure, WIDTH=4: 7*6 with out_ready=0 for 10 cycles -> out_valid and p=42 held stable. Raise out_ready -> IDLE next cycle, with in_ready=1.
- Reset mid-BUSY: assert rst_n=0 two cycles after accepting 9*9 -> out_valid=0, p=0, in_ready=1 immediately. A new 2*2 afterwards gives p=4.
- With SEQ_MULT_SIGNED_EN, WIDTH=4, signed_mode=1:
  - a=-3, b=5 -> p=8'hF1 (-15);
  - a=-8, b=-8 -> p=64;
  - signed_mode=0 with a=4'hD, b=5 -> p=65.
